// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: instruction-sequencing controller for the 8-phase accumulator CPU.
//
// The controller steps a 3-bit phase counter through fetch, decode and execute. It
// decodes the datapath strobes from the registered phase, the mode and the opcode.
// It adds four features:
//   - a memory-ready handshake that stalls the phase during wait states
//   - a sticky bus-timeout error
//   - a resumable halt
//   - trapping of illegal opcodes
//
// Optional feature macro: CPU_CTRL_SINGLE_STEP_EN
//   When defined, the design adds a 'step' input and a PAUSED mode. Every instruction
//   completion (P7 -> P0) parks in PAUSED. A step pulse starts the next instruction.
//   Reset also enters PAUSED.
//
// Ports:
//   clk      rising-edge clock
//   rst_     synchronous active-low reset
//   opcode   current IR opcode (only the low 3 bits encode ops)
//   zero     accumulator-zero flag
//   mem_rdy  memory access completes this cycle
//   resume   single-cycle pulse that releases HALTED
//   step     (single-step build only) starts the next instruction from PAUSED
//   rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, sel   datapath strobes
//   halt     CPU halted (HALTED or ERROR)
//   phase    current phase
//   stall    phase held awaiting mem_rdy
//   bus_err  sticky memory timeout error
//   illegal  sticky illegal-opcode flag
module cpu_ctrl_seq #(
    parameter int unsigned OPC_W    = 3,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_rdy,
    input  logic             resume,
`ifdef CPU_CTRL_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             rd,
    output logic             wr,
    output logic             ld_ir,
    output logic             ld_ac,
    output logic             ld_pc,
    output logic             inc_pc,
    output logic             data_e,
    output logic             sel,
    output logic             halt,
    output logic [2:0]       phase,
    output logic             stall,
    output logic             bus_err,
    output logic             illegal
);

    typedef enum logic [1:0] {
        ModeRun,
        ModeHalted,
        ModeError,
        ModePaused
    } mode_e;

    localparam logic [2:0] OpHlt = 3'd0;
    localparam logic [2:0] OpSkz = 3'd1;
    localparam logic [2:0] OpAdd = 3'd2;
    localparam logic [2:0] OpAnd = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpLda = 3'd5;
    localparam logic [2:0] OpSto = 3'd6;
    localparam logic [2:0] OpJmp = 3'd7;

    localparam logic [7:0] WaitMax = 8'(WAIT_MAX);

`ifdef CPU_CTRL_SINGLE_STEP_EN
    localparam mode_e ResetMode = ModePaused;
`else
    localparam mode_e ResetMode = ModeRun;
`endif

    mode_e      mode_q, mode_d;
    logic [2:0] phase_q, phase_d;
    logic [7:0] wait_q, wait_d;
    logic       bus_err_q, bus_err_d;
    logic       illegal_q, illegal_d;

    logic       illegal_op;
    logic [2:0] op;
    logic       alu_op;
    logic       is_sto;
    logic       mem_phase;
    logic       stall_run;

    // Any opcode bit above bit 2 marks the opcode as illegal.
    if (OPC_W > 3) begin : g_wide_opc
        assign illegal_op = |opcode[OPC_W-1:3];
    end else begin : g_narrow_opc
        assign illegal_op = 1'b0;
    end

    // An illegal opcode executes as HLT, so it also suppresses the ALU strobes.
    assign op     = illegal_op ? OpHlt : opcode[2:0];
    assign alu_op = (op == OpAdd) || (op == OpAnd) || (op == OpXor) || (op == OpLda);
    assign is_sto = (op == OpSto);

    assign mem_phase = (phase_q == 3'd2) || ((phase_q == 3'd7) && (alu_op || is_sto));
    assign stall_run = (mode_q == ModeRun) && mem_phase && !mem_rdy;

    // Strobe decode
    always_comb begin
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        data_e = 1'b0;
        sel    = 1'b0;
        if (mode_q == ModeRun) begin
            unique case (phase_q)
                3'd0: sel = 1'b1;
                3'd1: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                3'd2, 3'd3: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                3'd4: inc_pc = 1'b1;
                3'd5: rd = alu_op;
                3'd6: begin
                    rd     = alu_op;
                    data_e = is_sto;
                end
                3'd7: begin
                    rd     = alu_op;
                    ld_ac  = alu_op;
                    data_e = is_sto;
                    wr     = is_sto;
                    ld_pc  = (op == OpJmp);
                    inc_pc = (op == OpSkz) && zero;
                end
                default: ;
            endcase
        end else if (mode_q == ModePaused) begin
            sel = 1'b1;
        end
    end

    assign halt    = (mode_q == ModeHalted) || (mode_q == ModeError);
    assign phase   = phase_q;
    assign stall   = stall_run;
    assign bus_err = bus_err_q;
    assign illegal = illegal_q;

    // Next-state logic
    always_comb begin
        mode_d    = mode_q;
        phase_d   = phase_q;
        wait_d    = wait_q;
        bus_err_d = bus_err_q;
        illegal_d = illegal_q;
        unique case (mode_q)
            ModeRun: begin
                if (stall_run) begin
                    // A wait state at the limit with no ready is fatal. If mem_rdy
                    // arrives on the limit cycle, the access still completes.
                    if (wait_q == WaitMax) begin
                        mode_d    = ModeError;
                        bus_err_d = 1'b1;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end else begin
                    wait_d = 8'd0;
                    if ((phase_q == 3'd4) && (op == OpHlt)) begin
                        mode_d    = ModeHalted;
                        phase_d   = 3'd5;
                        illegal_d = illegal_q | illegal_op;
                    end else begin
                        phase_d = phase_q + 3'd1;
`ifdef CPU_CTRL_SINGLE_STEP_EN
                        if (phase_q == 3'd7) begin
                            mode_d = ModePaused;
                        end
`endif
                    end
                end
            end
            ModeHalted: begin
                if (resume) begin
                    mode_d = ModeRun;
                end
            end
            ModeError: ;
            ModePaused: begin
`ifdef CPU_CTRL_SINGLE_STEP_EN
                if (step) begin
                    mode_d  = ModeRun;
                    phase_d = 3'd1;
                end
`endif
            end
            default: mode_d = ModeError;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            mode_q    <= ResetMode;
            phase_q   <= 3'd0;
            wait_q    <= 8'd0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            phase_q   <= phase_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq (built with OPC_W=4, WAIT_MAX=4).
// Each cycle the bench drives inputs and pushes the expected
// {phase, strobes, flags} onto a scoreboard. It then pops the entry and
// compares it with the DUT outputs.
//   strobes = {rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, sel}
//   flags   = {halt, stall, bus_err, illegal}
module tb_cpu_ctrl_seq;

    localparam int unsigned OPC_W    = 4;
    localparam int unsigned WAIT_MAX = 4;

    localparam logic [7:0] S_RD   = 8'h80;
    localparam logic [7:0] S_WR   = 8'h40;
    localparam logic [7:0] S_LDIR = 8'h20;
    localparam logic [7:0] S_LDAC = 8'h10;
    localparam logic [7:0] S_LDPC = 8'h08;
    localparam logic [7:0] S_INC  = 8'h04;
    localparam logic [7:0] S_DE   = 8'h02;
    localparam logic [7:0] S_SEL  = 8'h01;
    localparam logic [7:0] S_NONE = 8'h00;

    localparam logic [3:0] F_HALT = 4'h8;
    localparam logic [3:0] F_STL  = 4'h4;
    localparam logic [3:0] F_BERR = 4'h2;
    localparam logic [3:0] F_ILL  = 4'h1;
    localparam logic [3:0] F_NONE = 4'h0;

    logic             clk = 1'b0;
    logic             rst_ = 1'b0;
    logic [OPC_W-1:0] opcode = '0;
    logic             zero = 1'b0;
    logic             mem_rdy = 1'b1;
    logic             resume = 1'b0;
`ifdef CPU_CTRL_SINGLE_STEP_EN
    logic             step = 1'b1;
`endif
    logic rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, sel;
    logic halt, stall, bus_err, illegal;
    logic [2:0] phase;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [14:0] v;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    cpu_ctrl_seq #(
        .OPC_W   (OPC_W),
        .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk    (clk),
        .rst_   (rst_),
        .opcode (opcode),
        .zero   (zero),
        .mem_rdy(mem_rdy),
        .resume (resume),
`ifdef CPU_CTRL_SINGLE_STEP_EN
        .step   (step),
`endif
        .rd     (rd),
        .wr     (wr),
        .ld_ir  (ld_ir),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .inc_pc (inc_pc),
        .data_e (data_e),
        .sel    (sel),
        .halt   (halt),
        .phase  (phase),
        .stall  (stall),
        .bus_err(bus_err),
        .illegal(illegal)
    );

    task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got ph=%0d s=%02h f=%01h, want ph=%0d s=%02h f=%01h",
                     tag, got[14:12], got[11:4], got[3:0], exp[14:12], exp[11:4], exp[3:0]);
        end
    endtask

    // One clock: drive inputs on the falling edge, queue the expectation, then compare.
    task automatic cyc(input string tag, input logic [3:0] op, input logic z, input logic rdy,
                       input logic res, input logic [2:0] ph, input logic [7:0] s,
                       input logic [3:0] f);
        exp_t e;
        @(negedge clk);
        rst_    = 1'b1;
        opcode  = op;
        zero    = z;
        mem_rdy = rdy;
        resume  = res;
        sb.push_back('{tag, {ph, s, f}});
        #1;
        e = sb.pop_front();
        check_eq(e.tag, {phase, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, sel,
                         halt, stall, bus_err, illegal}, e.v);
    endtask

    // Reset is applied on the next rising edge; the following cyc() releases it.
    task automatic do_reset();
        @(negedge clk);
        rst_    = 1'b0;
        mem_rdy = 1'b1;
        resume  = 1'b0;
    endtask

    // P0..P4 with memory ready.
    task automatic fetch(input string tag, input logic [3:0] op, input logic z);
        cyc({tag, "_p0"}, op, z, 1'b1, 1'b0, 3'd0, S_SEL, F_NONE);
        cyc({tag, "_p1"}, op, z, 1'b1, 1'b0, 3'd1, S_SEL | S_RD, F_NONE);
        cyc({tag, "_p2"}, op, z, 1'b1, 1'b0, 3'd2, S_SEL | S_RD | S_LDIR, F_NONE);
        cyc({tag, "_p3"}, op, z, 1'b1, 1'b0, 3'd3, S_SEL | S_RD | S_LDIR, F_NONE);
        cyc({tag, "_p4"}, op, z, 1'b1, 1'b0, 3'd4, S_INC, F_NONE);
    endtask

    initial begin
        // ADD, full instruction; resume in RUN is ignored.
        do_reset();
        fetch("add", 4'h2, 1'b0);
        cyc("add_p5", 4'h2, 1'b0, 1'b1, 1'b1, 3'd5, S_RD, F_NONE);
        cyc("add_p6", 4'h2, 1'b0, 1'b1, 1'b0, 3'd6, S_RD, F_NONE);
        cyc("add_p7", 4'h2, 1'b0, 1'b1, 1'b0, 3'd7, S_RD | S_LDAC, F_NONE);

        // STO with three wait states at P7.
        fetch("sto", 4'h6, 1'b0);
        cyc("sto_p5", 4'h6, 1'b0, 1'b1, 1'b0, 3'd5, S_NONE, F_NONE);
        cyc("sto_p6", 4'h6, 1'b0, 1'b1, 1'b0, 3'd6, S_DE, F_NONE);
        for (int i = 0; i < 3; i++) begin
            cyc("sto_p7_wait", 4'h6, 1'b0, 1'b0, 1'b0, 3'd7, S_DE | S_WR, F_STL);
        end
        cyc("sto_p7_rdy", 4'h6, 1'b0, 1'b1, 1'b0, 3'd7, S_DE | S_WR, F_NONE);
        cyc("sto_wrap", 4'h6, 1'b0, 1'b1, 1'b0, 3'd0, S_SEL, F_NONE);

        // Ready arrives exactly when the wait counter reaches the limit: no error.
        do_reset();
        cyc("lim_p0", 4'h2, 1'b0, 1'b1, 1'b0, 3'd0, S_SEL, F_NONE);
        cyc("lim_p1", 4'h2, 1'b0, 1'b1, 1'b0, 3'd1, S_SEL | S_RD, F_NONE);
        for (int i = 0; i < 4; i++) begin
            cyc("lim_wait", 4'h2, 1'b0, 1'b0, 1'b0, 3'd2, S_SEL | S_RD | S_LDIR, F_STL);
        end
        cyc("lim_rdy", 4'h2, 1'b0, 1'b1, 1'b0, 3'd2, S_SEL | S_RD | S_LDIR, F_NONE);
        cyc("lim_p3", 4'h2, 1'b0, 1'b1, 1'b0, 3'd3, S_SEL | S_RD | S_LDIR, F_NONE);

        // Timeout: five stall cycles, then sticky ERROR that ignores rdy and resume.
        do_reset();
        cyc("to_p0", 4'h2, 1'b0, 1'b1, 1'b0, 3'd0, S_SEL, F_NONE);
        cyc("to_p1", 4'h2, 1'b0, 1'b1, 1'b0, 3'd1, S_SEL | S_RD, F_NONE);
        for (int i = 0; i < 5; i++) begin
            cyc("to_wait", 4'h2, 1'b0, 1'b0, 1'b0, 3'd2, S_SEL | S_RD | S_LDIR, F_STL);
        end
        for (int i = 0; i < 3; i++) begin
            cyc("to_err", 4'h2, 1'b0, 1'b1, 1'b1, 3'd2, S_NONE, F_HALT | F_BERR);
        end
        do_reset();
        cyc("to_reset", 4'h2, 1'b0, 1'b1, 1'b0, 3'd0, S_SEL, F_NONE);

        // HLT, then resume returns to P5.
        do_reset();
        fetch("hlt", 4'h0, 1'b0);
        cyc("hlt_hold0", 4'h0, 1'b0, 1'b1, 1'b0, 3'd5, S_NONE, F_HALT);
        cyc("hlt_hold1", 4'h0, 1'b0, 1'b1, 1'b0, 3'd5, S_NONE, F_HALT);
        cyc("hlt_resume", 4'h0, 1'b0, 1'b1, 1'b1, 3'd5, S_NONE, F_HALT);
        cyc("hlt_p5", 4'h0, 1'b0, 1'b1, 1'b0, 3'd5, S_NONE, F_NONE);
        cyc("hlt_p6", 4'h0, 1'b0, 1'b1, 1'b0, 3'd6, S_NONE, F_NONE);
        cyc("hlt_p7", 4'h0, 1'b0, 1'b1, 1'b0, 3'd7, S_NONE, F_NONE);

        // SKZ taken, SKZ not taken, JMP.
        fetch("skz1", 4'h1, 1'b1);
        cyc("skz1_p5", 4'h1, 1'b1, 1'b1, 1'b0, 3'd5, S_NONE, F_NONE);
        cyc("skz1_p6", 4'h1, 1'b1, 1'b1, 1'b0, 3'd6, S_NONE, F_NONE);
        cyc("skz1_p7", 4'h1, 1'b1, 1'b0, 1'b0, 3'd7, S_INC, F_NONE);
        fetch("skz0", 4'h1, 1'b0);
        cyc("skz0_p5", 4'h1, 1'b0, 1'b1, 1'b0, 3'd5, S_NONE, F_NONE);
        cyc("skz0_p6", 4'h1, 1'b0, 1'b1, 1'b0, 3'd6, S_NONE, F_NONE);
        cyc("skz0_p7", 4'h1, 1'b0, 1'b1, 1'b0, 3'd7, S_NONE, F_NONE);
        fetch("jmp", 4'h7, 1'b0);
        cyc("jmp_p5", 4'h7, 1'b0, 1'b1, 1'b0, 3'd5, S_NONE, F_NONE);
        cyc("jmp_p6", 4'h7, 1'b0, 1'b1, 1'b0, 3'd6, S_NONE, F_NONE);
        cyc("jmp_p7", 4'h7, 1'b0, 1'b1, 1'b0, 3'd7, S_LDPC, F_NONE);

        // Illegal opcode traps like HLT; reset mid-halt clears it.
        do_reset();
        fetch("ill", 4'hA, 1'b0);
        cyc("ill_halt", 4'hA, 1'b0, 1'b1, 1'b0, 3'd5, S_NONE, F_HALT | F_ILL);
        do_reset();
        cyc("ill_reset", 4'h2, 1'b0, 1'b1, 1'b0, 3'd0, S_SEL, F_NONE);

        // Illegal flag stays set after resume.
        do_reset();
        fetch("ill2", 4'hA, 1'b0);
        cyc("ill2_halt", 4'hA, 1'b0, 1'b1, 1'b0, 3'd5, S_NONE, F_HALT | F_ILL);
        cyc("ill2_resume", 4'h0, 1'b0, 1'b1, 1'b1, 3'd5, S_NONE, F_HALT | F_ILL);
        cyc("ill2_p5", 4'h0, 1'b0, 1'b1, 1'b0, 3'd5, S_NONE, F_ILL);
        cyc("ill2_p6", 4'h0, 1'b0, 1'b1, 1'b0, 3'd6, S_NONE, F_ILL);

        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
- Parametrised instruction-sequencing controller for the 8-phase accumulator CPU: fetch, decode, execute over a 3-bit phase counter.
- Adds a memory-ready handshake with wait-state stalling, a bus-timeout error, a resumable halt and illegal-opcode trapping.
- Sits between the instruction register (opcode), the ALU zero flag and the PC/AC/IR/memory-bus strobes.

Parameters:
- OPC_W, 3, opcode width (>=3); only low 3 bits encode ops, upper bits must be 0.
- WAIT_MAX, 15, max stall cycles per memory phase before bus error (1..255).

Ports:
- clk  in  1  clock, rising edge
- rst_  in  1  reset, synchronous, active-low
- opcode  in  OPC_W  current IR opcode
- zero  in  1  accumulator-zero flag
- mem_rdy  in  1  memory access completes this cycle
- resume  in  1  single-cycle pulse; releases HALTED
- rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, sel  out  1 each  datapath strobes
- halt  out  1  CPU halted (HALTED or ERROR)
- phase  out  3  current phase
- stall  out  1  phase held awaiting mem_rdy
- bus_err  out  1  sticky timeout error
- illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Interface: one clock (clk); reset rst_ is synchronous and active-low. Sampled only on the clk rising edge.
- Reset: phase=0, mode=RUN, wait counter=0, bus_err=0, illegal=0.
- Strobes are combinational decode of registered phase, mode and opcode. After reset: sel=1, all other outputs 0.
- Op encoding (low 3 bits): HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- alu_op = ADD|AND|XOR|LDA.
- illegal_op = any opcode bit above bit 2 set; it is executed as HLT.
- Phase decode in RUN (unlisted strobes are 0):
  - P0 INST_ADDR: sel=1.
  - P1 INST_FETCH: sel=1, rd=1.
  - P2 INST_LOAD: sel=1, rd=1, ld_ir=1. Memory phase.
  - P3 IDLE: sel=1, rd=1, ld_ir=1.
  - P4 OP_ADDR: inc_pc=1.
  - P5 OP_FETCH: rd=alu_op.
  - P6 ALU_OP: rd=alu_op; data_e=STO.
  - P7 STORE: rd=alu_op; ld_ac=alu_op; data_e=STO; wr=STO; ld_pc=JMP; inc_pc=SKZ&zero. Memory phase when alu_op|STO.
- Advance rule: phase increments mod 8 each cycle, except at a memory phase with mem_rdy=0.
  - Then phase holds, stall=1 and the strobes stay stable.
  - The wait counter increments each stall cycle and clears on any advance.
- Timeout: if the counter equals WAIT_MAX and mem_rdy=0, the next state is ERROR.
  - ERROR: bus_err=1, halt=1, all strobes 0, phase frozen. Exited only by reset.
  - mem_rdy=1 on the same cycle as the counter reaching WAIT_MAX counts as success (no error).
- HLT / illegal: at P4 with HLT or illegal_op, inc_pc=1 as normal. The next state is HALTED with phase=5; illegal_op also sets illegal.
  - HALTED: halt=1, all strobes 0, phase held.
  - resume=1 while HALTED returns to RUN at P5 on the next edge; illegal remains set.
  - resume in RUN or ERROR is ignored.
- Wrap: P7 to P0 only on advance.
- Reset mid-stall or mid-halt returns everything to reset values on the next edge.
- Opcode is sampled combinationally. The IR must hold opcode stable from P3 to P7.

Optional Feature:
- CPU_CTRL_SINGLE_STEP_EN. When defined, adds input step (1 bit) and state PAUSED.
  - Every P7 to P0 advance enters PAUSED: phase=0, sel=1, other strobes 0, halt=0.
  - A step pulse starts the next instruction (P0 to P1 on the following edge).
  - Reset enters PAUSED.
- When undefined: no step port; the FSM free-runs from reset.

Test Plan:
- Reset with opcode=ADD, mem_rdy=1 → after release, phase counts 0..7 in 8 cycles. rd=1 in P1–P3 and P5–P7; ld_ac=1 only in P7; stall never 1.
- STO, mem_rdy low for 3 cycles at P7 → phase holds at 7 for 3 cycles with stall=1 and wr=1 steady. Advances to P0 on the cycle after mem_rdy=1.
- WAIT_MAX=4, mem_rdy stuck 0 at P2 → after 5 stall cycles bus_err=1, halt=1, all strobes 0. Stays that way until rst_=0.
- opcode=HLT → halt=1 from the cycle after P4, phase=5. A resume pulse clears halt and P6 follows.
- SKZ with zero=1 → inc_pc=1 at P4 and P7. With zero=0 → inc_pc=1 at P4 only. JMP → ld_pc=1 at P7.
- OPC_W=4, opcode=4'b1010 → illegal=1, halt=1 after P4. With CPU_CTRL_SINGLE_STEP_EN, a completed ADD pauses at P0 until step.
